// File: rtl/reservation_station_add.sv
// Single-entry add/sub reservation station with CDB snooping.
// Operands forward from the CDB at issue time and while waiting.
module reservation_station_add #(
  parameter logic [2:0]  MY_TAG      = 3'd1,
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Issue,
  input  logic        Issue_Op,
  input  logic [15:0] Issue_Vj,
  input  logic [15:0] Issue_Vk,
  input  logic [2:0]  Issue_Qj,
  input  logic [2:0]  Issue_Qk,
  input  logic [2:0]  Qi_CDB,
  input  logic [15:0] Qi_CDB_data,
  output logic        Busy,
  output logic        Done_ADD,
  output logic [15:0] Q_ADD
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPS,
    EXEC,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic        op_q;
  logic [15:0] vj_q;
  logic [15:0] vk_q;
  logic [15:0] q_q;
  logic [2:0]  qj_q;
  logic [2:0]  qk_q;
  logic [3:0]  cnt_q;

  logic [15:0] src_vj;
  logic [15:0] src_vk;
  logic [2:0]  src_qj;
  logic [2:0]  src_qk;
  logic        hit_j;
  logic        hit_k;
  logic [15:0] vj_d;
  logic [15:0] vk_d;
  logic [2:0]  qj_d;
  logic [2:0]  qk_d;
  logic        ready_d;
  logic [15:0] res;
  logic        grant;

  // In IDLE the incoming issue fields are snooped, otherwise the stored ones.
  always_comb begin
    src_vj  = vj_q;
    src_vk  = vk_q;
    src_qj  = qj_q;
    src_qk  = qk_q;
    if (state_q == IDLE) begin
      src_vj = Issue_Vj;
      src_vk = Issue_Vk;
      src_qj = Issue_Qj;
      src_qk = Issue_Qk;
    end
    hit_j   = (Qi_CDB != 3'd0) && (Qi_CDB == src_qj);
    hit_k   = (Qi_CDB != 3'd0) && (Qi_CDB == src_qk);
    vj_d    = hit_j ? Qi_CDB_data : src_vj;
    vk_d    = hit_k ? Qi_CDB_data : src_vk;
    qj_d    = hit_j ? 3'd0 : src_qj;
    qk_d    = hit_k ? 3'd0 : src_qk;
    ready_d = (qj_d == 3'd0) && (qk_d == 3'd0);
  end

  assign res   = op_q ? (vj_q - vk_q) : (vj_q + vk_q);
  assign grant = (Qi_CDB == MY_TAG);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= 1'b0;
      vj_q    <= 16'h0000;
      vk_q    <= 16'h0000;
      q_q     <= 16'h0000;
      qj_q    <= 3'd0;
      qk_q    <= 3'd0;
      cnt_q   <= 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Issue) begin
            busy_q <= 1'b1;
            op_q   <= Issue_Op;
            vj_q   <= vj_d;
            vk_q   <= vk_d;
            qj_q   <= qj_d;
            qk_q   <= qk_d;
            if (ready_d) begin
              state_q <= EXEC;
              cnt_q   <= CNT_INIT;
            end else begin
              state_q <= WAIT_OPS;
            end
          end
        end
        WAIT_OPS: begin
          vj_q <= vj_d;
          vk_q <= vk_d;
          qj_q <= qj_d;
          qk_q <= qk_d;
          if (ready_d) begin
            state_q <= EXEC;
            cnt_q   <= CNT_INIT;
          end
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            q_q     <= res;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (grant) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy     = busy_q;
  assign Done_ADD = done_q;
  assign Q_ADD    = q_q;

endmodule

// File: tb/tb_reservation_station_add.sv
// Directed bench for reservation_station_add.
// Expected results queue at issue and are popped when Done_ADD rises.
module tb_reservation_station_add;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Issue = 1'b0;
  logic        Issue_Op = 1'b0;
  logic [15:0] Issue_Vj = '0;
  logic [15:0] Issue_Vk = '0;
  logic [2:0]  Issue_Qj = '0;
  logic [2:0]  Issue_Qk = '0;
  logic [2:0]  Qi_CDB = '0;
  logic [15:0] Qi_CDB_data = '0;
  logic        Busy;
  logic        Done_ADD;
  logic [15:0] Q_ADD;

  int passed = 0;
  int total  = 0;
  logic [15:0] exp_q[$];

  reservation_station_add #(
    .MY_TAG(3'd1),
    .EXEC_CYCLES(2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Issue(Issue),
    .Issue_Op(Issue_Op),
    .Issue_Vj(Issue_Vj),
    .Issue_Vk(Issue_Vk),
    .Issue_Qj(Issue_Qj),
    .Issue_Qk(Issue_Qk),
    .Qi_CDB(Qi_CDB),
    .Qi_CDB_data(Qi_CDB_data),
    .Busy(Busy),
    .Done_ADD(Done_ADD),
    .Q_ADD(Q_ADD)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic op,
                       input logic [15:0] vj,
                       input logic [15:0] vk,
                       input logic [2:0] qj,
                       input logic [2:0] qk);
    Issue    = 1'b1;
    Issue_Op = op;
    Issue_Vj = vj;
    Issue_Vk = vk;
    Issue_Qj = qj;
    Issue_Qk = qk;
    tick();
    Issue = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [15:0] d);
    Qi_CDB      = tag;
    Qi_CDB_data = d;
  endtask

  // lat = cycles from now until Done_ADD must first read 1
  task automatic wait_done(input string tag, input int lat);
    int n = 0;
    while (!Done_ADD && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_done"}, {31'd0, Done_ADD}, 32'd1);
    chk({tag, "_sb"}, exp_q.size(), 32'd1);
    if (exp_q.size() > 0) chk({tag, "_q"}, {16'd0, Q_ADD}, {16'd0, exp_q.pop_front()});
  endtask

  task automatic grant(input string tag, input logic [15:0] q_hold);
    cdb(3'd1, 16'hBEEF);
    tick();
    cdb(3'd0, 16'h0000);
    chk({tag, "_gdone"}, {31'd0, Done_ADD}, 32'd0);
    chk({tag, "_gbusy"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_gq"}, {16'd0, Q_ADD}, {16'd0, q_hold});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, Done_ADD}, 32'd0);
    chk({tag, "_q"}, {16'd0, Q_ADD}, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    Reset = 1'b0;
    chk_idle("reset");

    // simple add, hold in DONE, foreign tag is not a grant
    issue(1'b0, 16'd5, 16'd7, 3'd0, 3'd0);
    exp_q.push_back(16'd12);
    chk("add_busy", {31'd0, Busy}, 32'd1);
    wait_done("add", 2);
    cdb(3'd2, 16'h0055);
    tick();
    chk("hold_done", {31'd0, Done_ADD}, 32'd1);
    chk("hold_q", {16'd0, Q_ADD}, 32'd12);
    cdb(3'd0, 16'h0000);
    grant("add", 16'd12);

    // subtract waiting on Qj
    issue(1'b1, 16'h7777, 16'd4, 3'd3, 3'd0);
    exp_q.push_back(16'd6);
    for (int i = 0; i < 3; i++) begin
      chk("sub_wait_busy", {31'd0, Busy}, 32'd1);
      chk("sub_wait_done", {31'd0, Done_ADD}, 32'd0);
      tick();
    end
    cdb(3'd3, 16'd10);
    tick();
    cdb(3'd0, 16'h0000);
    wait_done("sub", 2);
    grant("sub", 16'd6);

    // both operands pending, resolved on separate cycles
    issue(1'b0, 16'h0000, 16'h0000, 3'd3, 3'd4);
    exp_q.push_back(16'd11);
    cdb(3'd4, 16'd2);
    tick();
    cdb(3'd0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("two_wait_done", {31'd0, Done_ADD}, 32'd0);
    end
    cdb(3'd3, 16'd9);
    tick();
    cdb(3'd0, 16'h0000);
    wait_done("two", 2);
    grant("two", 16'd11);

    // issue-time forwarding with wraparound
    cdb(3'd3, 16'hFFFF);
    issue(1'b0, 16'h1234, 16'd1, 3'd3, 3'd0);
    exp_q.push_back(16'h0000);
    cdb(3'd0, 16'h0000);
    wait_done("fwd", 2);
    grant("fwd", 16'h0000);

    // issue while busy, issue during grant, then MY_TAG forwarding
    issue(1'b0, 16'd100, 16'd200, 3'd0, 3'd0);
    exp_q.push_back(16'd300);
    issue(1'b1, 16'd1, 16'd1, 3'd0, 3'd0);
    chk("busy_ign_busy", {31'd0, Busy}, 32'd1);
    chk("busy_ign_done", {31'd0, Done_ADD}, 32'd0);
    wait_done("busy_ign", 1);
    cdb(3'd1, 16'h0020);
    issue(1'b1, 16'd50, 16'd8, 3'd0, 3'd0);
    chk("gissue_busy", {31'd0, Busy}, 32'd0);
    chk("gissue_done", {31'd0, Done_ADD}, 32'd0);
    chk("gissue_q", {16'd0, Q_ADD}, 32'd300);
    tick();
    chk("gissue_idle", {31'd0, Busy}, 32'd0);
    issue(1'b0, 16'h1234, 16'd5, 3'd1, 3'd0);
    exp_q.push_back(16'h0025);
    cdb(3'd0, 16'h0000);
    chk("mytag_busy", {31'd0, Busy}, 32'd1);
    wait_done("mytag", 2);
    grant("mytag", 16'h0025);

    // reset mid-EXEC
    issue(1'b0, 16'd1, 16'd2, 3'd0, 3'd0);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_idle("rst_exec");
    tick();
    chk("rst_exec_stay", {31'd0, Done_ADD}, 32'd0);

    // reset in DONE
    issue(1'b0, 16'd3, 16'd4, 3'd0, 3'd0);
    exp_q.push_back(16'd7);
    wait_done("pre_rst", 2);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_idle("rst_done");

    // reset outranks issue
    Reset = 1'b1;
    issue(1'b0, 16'd9, 16'd9, 3'd0, 3'd0);
    Reset = 1'b0;
    chk_idle("rst_prio");

    // fresh work after reset
    issue(1'b1, 16'd3, 16'd5, 3'd0, 3'd0);
    exp_q.push_back(16'hFFFE);
    wait_done("post_rst", 2);
    grant("post_rst", 16'hFFFE);
    issue(1'b0, 16'h8000, 16'h8001, 3'd0, 3'd0);
    exp_q.push_back(16'h0001);
    wait_done("carry", 2);
    grant("carry", 16'h0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reservation_station_add.md
RESERVATION_STATION_ADD -- requirements
Module: reservation_station_add

Interface
REQ-001 Parameter MY_TAG, default 3'd1: reservation-station tag this block broadcasts on, and recognises on, the CDB.
REQ-002 Parameter EXEC_CYCLES, default 2, legal range 1..15: execution latency in cycles.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  synchronous, active-high.
REQ-005 Issue  input  1  issue strobe; one instruction per cycle high.
REQ-006 Issue_Op  input  1  0 = add, 1 = subtract (Vj - Vk).
REQ-007 Issue_Vj, Issue_Vk  input  16 each  operand values; valid only when the matching tag is 0.
REQ-008 Issue_Qj, Issue_Qk  input  3 each  producer tags; 0 = value already present.
REQ-009 Qi_CDB  input  3  tag currently driven on the CDB; 0 = no producer.
REQ-010 Qi_CDB_data  input  16  data currently driven on the CDB.
REQ-011 Busy  output  1  station occupied (state != IDLE).
REQ-012 Done_ADD  output  1  result ready, requesting the CDB.
REQ-013 Q_ADD  output  16  result presented to the CDB arbiter.

Function
REQ-014 The block SHALL implement states IDLE, WAIT_OPS, EXEC and DONE; all outputs SHALL be registered.
REQ-015 CDB match on an operand SHALL occur when Qi_CDB != 0 and Qi_CDB == the stored operand tag; on a match, Vx <= Qi_CDB_data and Qx <= 0.
REQ-016 In IDLE with Issue=1, the block SHALL capture Op, Vj, Vk, Qj and Qk, applying REQ-015 in the same cycle against the incoming Issue_Qj and Issue_Qk (issue-time forwarding).
REQ-017 From IDLE, after capture, the block SHALL go to EXEC if both resolved tags are 0, else to WAIT_OPS.
REQ-018 Issue while Busy=1 SHALL be ignored, with no state change.
REQ-019 In WAIT_OPS the block SHALL apply REQ-015 every cycle to each pending operand independently; both operands may resolve in the same cycle.
REQ-020 The block SHALL go from WAIT_OPS to EXEC on the edge at which both tags become 0.
REQ-021 On entering EXEC, a down-counter SHALL load EXEC_CYCLES-1.
REQ-022 EXEC SHALL decrement the counter each cycle and leave for DONE when the counter reaches 0.
REQ-023 Latency SHALL therefore be exactly EXEC_CYCLES cycles from EXEC entry to Done_ADD=1.
REQ-024 On the EXEC->DONE edge, Q_ADD SHALL be loaded with Vj+Vk (Op=0) or Vj-Vk (Op=1), modulo 2^16, with no carry or overflow flag, and Done_ADD SHALL be set to 1.
REQ-025 In DONE, Done_ADD and Q_ADD SHALL hold stable until grant, where grant = (Qi_CDB == MY_TAG).
REQ-026 On grant, the block SHALL return to IDLE with Done_ADD=0 and Busy=0; Q_ADD SHALL keep its value.
REQ-027 A grant observed outside DONE SHALL have no effect.
REQ-028 An Issue in the same cycle as the DONE->IDLE transition SHALL be ignored; the earliest accepted issue is the following cycle.
REQ-029 Operand tags equal to MY_TAG are legal after the station returns to IDLE and SHALL match the still-held CDB value per REQ-015.

Reset
REQ-030 Reset SHALL have priority over every other input.
REQ-031 Reset SHALL be effective in any state, including mid-EXEC and in DONE.
REQ-032 On the Reset edge, the block SHALL enter IDLE with Busy=0, Done_ADD=0, Q_ADD=16'h0000, Vj=Vk=0, Qj=Qk=0, Op=0 and counter=0, and any in-flight instruction is discarded.

Verification
REQ-033 Issue add, Vj=5, Vk=7, Qj=Qk=0, EXEC_CYCLES=2 -> Busy=1 next cycle; Done_ADD=1 and Q_ADD=12 two cycles after EXEC entry; Qi_CDB=1 -> Done_ADD=0 and Busy=0 next cycle.
REQ-034 Issue sub, Qj=3, Vk=4 while Qi_CDB=0; three cycles later Qi_CDB=3, Qi_CDB_data=10 -> EXEC next edge, Q_ADD=6.
REQ-035 Issue with Qj=3 and Qk=4 pending; CDB shows tag 4 (data 2), then tag 3 (data 9); op add -> Q_ADD=11 only after both matches.
REQ-036 Issue with Issue_Qj=3 in the same cycle Qi_CDB=3, Qi_CDB_data=16'hFFFF; Vk=1, add -> direct EXEC, Q_ADD=16'h0000 (wrap).
REQ-037 Second Issue while Busy, and Issue in the same cycle as grant -> both ignored; the first result is unaffected.
REQ-038 Reset asserted mid-EXEC and in DONE -> next cycle Busy=0, Done_ADD=0, Q_ADD=0; a fresh issue then completes normally.
